// File: rtl/sobels_pkg.sv
// Shared sizing helpers for the Sobel edge filter: gradient/magnitude widths,
// pixel maximum and counter widths derived from the image geometry.
package sobels_pkg;

  function automatic int grad_w(input int px_size);
    return px_size + 3;
  endfunction

  function automatic int mag_w(input int px_size);
    return px_size + 4;
  endfunction

  function automatic int px_max(input int px_size);
    return (1 << px_size) - 1;
  endfunction

  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sobel_window.sv
// Raster position counters, two line buffers and the 3x3 neighbourhood whose
// right-hand column is the pixel arriving this cycle.
module sobel_window
  import sobels_pkg::*;
#(
  parameter int PX_SIZE      = 8,
  parameter int IMAGE_WIDTH  = 400,
  parameter int IMAGE_HEIGHT = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PX_SIZE-1:0]       px,
  input  logic                     px_vld,
  output logic [8:0][PX_SIZE-1:0]  win,
  output logic                     border
);

  localparam int CW = cnt_w(IMAGE_WIDTH);
  localparam int RW = cnt_w(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [PX_SIZE-1:0] lb1 [IMAGE_WIDTH];
  logic [PX_SIZE-1:0] lb2 [IMAGE_WIDTH];

  // Index 0 is the top row of the window, index 2 the current line.
  logic [2:0][PX_SIZE-1:0] col_c2, col_c1, col_cur;

  assign col_cur = {px, lb1[col], lb2[col]};
  assign border  = (row < RW'(2)) || (col < CW'(2));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win[i*3 + 0] = col_c2[i];
      win[i*3 + 1] = col_c1[i];
      win[i*3 + 2] = col_cur[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      col_c2 <= '0;
      col_c1 <= '0;
    end else if (px_vld) begin
      col_c2 <= col_c1;
      col_c1 <= col_cur;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line memories are never cleared; stale contents are masked by border.
  always_ff @(posedge clk) begin
    if (px_vld) begin
      lb2[col] <= lb1[col];
      lb1[col] <= px;
    end
  end

endmodule

// File: rtl/top_sobels.sv
// Streaming Sobel magnitude filter: |Gx|+|Gy| saturated to the pixel width,
// one registered output per accepted pixel, zero on the two-pixel border.
module top_sobels
  import sobels_pkg::*;
#(
  parameter int PX_SIZE      = 8,
  parameter int IMAGE_WIDTH  = 400,
  parameter int IMAGE_HEIGHT = 400
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PX_SIZE-1:0] input_data,
  input  logic               input_data_valid,
  output logic [PX_SIZE-1:0] output_data,
  output logic               output_data_valid
);

  localparam int GW = grad_w(PX_SIZE);
  localparam int MW = mag_w(PX_SIZE);

  logic [8:0][PX_SIZE-1:0] win;
  logic                    border;
  logic signed [GW-1:0]    gx, gy;
  logic [MW-1:0]           mag;
  logic [PX_SIZE-1:0]      data_p0;
  logic                    vld_p0;

  function automatic logic signed [GW-1:0] ext(input logic [PX_SIZE-1:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic [MW-1:0] abs_mag(input logic signed [GW-1:0] g);
    logic signed [GW-1:0] n;
    n = (g < 0) ? -g : g;
    return {1'b0, n};
  endfunction

  function automatic logic [PX_SIZE-1:0] sat(input logic [MW-1:0] m);
    return (|m[MW-1:PX_SIZE]) ? PX_SIZE'(px_max(PX_SIZE)) : m[PX_SIZE-1:0];
  endfunction

  sobel_window #(
    .PX_SIZE     (PX_SIZE),
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_window (
    .clk   (clk),
    .rst   (resetn),
    .px    (input_data),
    .px_vld(input_data_valid),
    .win   (win),
    .border(border)
  );

  assign gx = (ext(win[2]) + (ext(win[5]) <<< 1) + ext(win[8]))
            - (ext(win[0]) + (ext(win[3]) <<< 1) + ext(win[6]));
  assign gy = (ext(win[6]) + (ext(win[7]) <<< 1) + ext(win[8]))
            - (ext(win[0]) + (ext(win[1]) <<< 1) + ext(win[2]));
  assign mag = abs_mag(gx) + abs_mag(gy);

  // Stage p0: output register; data holds across idle cycles.
  always_ff @(posedge clk) begin
    if (resetn) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= input_data_valid;
      if (input_data_valid) data_p0 <= border ? '0 : sat(mag);
    end
  end

  assign output_data       = data_p0;
  assign output_data_valid = vld_p0;

endmodule

// File: tb/tb_top_sobels.sv
// Randomised scoreboard bench for top_sobels on a reduced 20x10 frame.
module tb_top_sobels;

  localparam int PX = 8;
  localparam int W  = 20;
  localparam int H  = 10;
  localparam int N  = W * H;

  typedef struct { int exp; int r; int c; } item_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [PX-1:0] input_data = '0;
  logic          input_data_valid = 1'b0;
  logic [PX-1:0] output_data;
  logic          output_data_valid;

  int errors = 0;
  int checks = 0;
  item_t q[$];

  int img_m [H][W];
  int rnd_img [H][W];
  int mr = 0, mc = 0;

  int n_out = 0, n_nz = 0, n_255 = 0, n_4 = 0;
  logic          acc_d = 1'b0;
  logic          rst_d = 1'b1;
  logic [PX-1:0] last = '0;

  top_sobels #(.PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .input_data       (input_data),
    .input_data_valid (input_data_valid),
    .output_data      (output_data),
    .output_data_valid(output_data_valid)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Sobel magnitude centred at (y,x) on the model image.
  function automatic int ref_px(input int y, input int x);
    int gx, gy, m;
    gx = (img_m[y-1][x+1] + 2*img_m[y][x+1] + img_m[y+1][x+1])
       - (img_m[y-1][x-1] + 2*img_m[y][x-1] + img_m[y+1][x-1]);
    gy = (img_m[y+1][x-1] + 2*img_m[y+1][x] + img_m[y+1][x+1])
       - (img_m[y-1][x-1] + 2*img_m[y-1][x] + img_m[y-1][x+1]);
    m = iabs(gx) + iabs(gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic model_push(input int d);
    item_t it;
    img_m[mr][mc] = d;
    it.r = mr;
    it.c = mc;
    it.exp = (mr < 2 || mc < 2) ? 0 : ref_px(mr - 1, mc - 1);
    q.push_back(it);
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (c >= W/2) ? 255 : 0;
      2:       return c / 2;
      default: return rnd_img[r][c];
    endcase
  endfunction

  task automatic send(input int d, input bit gaps);
    while (gaps && $urandom_range(99) < 30) begin
      input_data_valid = 1'b0;
      input_data = PX'($urandom);
      @(posedge clk); #1;
    end
    input_data = PX'(d);
    input_data_valid = 1'b1;
    model_push(d);
    @(posedge clk); #1;
    input_data_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(pix(kind, r, c), gaps);
  endtask

  task automatic idle(input int n);
    input_data_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_stats();
    n_out = 0; n_nz = 0; n_255 = 0; n_4 = 0;
  endtask

  task automatic expect_count(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    acc_d <= input_data_valid && !resetn;
    rst_d <= resetn;
  end

  always @(negedge clk) begin
    item_t it;
    if (rst_d) begin
      checks++;
      if (output_data_valid !== 1'b0 || output_data !== '0) begin
        errors++;
        $display("FAIL reset_state: valid=%b data=%0d expected valid=0 data=0",
                 output_data_valid, output_data);
      end
      last = '0;
    end else begin
      checks++;
      if (output_data_valid !== acc_d) begin
        errors++;
        $display("FAIL valid_flag: got %b expected %b at %0t", output_data_valid, acc_d, $time);
      end
      if (output_data_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: data=%0d with no pixel pending", output_data);
        end else begin
          it = q.pop_front();
          if (output_data !== PX'(it.exp)) begin
            errors++;
            $display("FAIL pixel r=%0d c=%0d: got %0d expected %0d",
                     it.r, it.c, output_data, it.exp);
          end
        end
        n_out++;
        if (output_data != 0)   n_nz++;
        if (output_data == 255) n_255++;
        if (output_data == 4)   n_4++;
        last = output_data;
      end else begin
        checks++;
        if (output_data !== last) begin
          errors++;
          $display("FAIL hold: got %0d expected %0d at %0t", output_data, last, $time);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        rnd_img[r][c] = int'($urandom_range(255));

    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    idle(2);

    clear_stats();
    send_frame(0, 1'b0);
    idle(3);
    expect_count("flat_outputs", n_out, N);
    expect_count("flat_nonzero", n_nz, 0);

    clear_stats();
    send_frame(1, 1'b0);
    idle(3);
    expect_count("step_255", n_255, 2 * (H - 2));
    expect_count("step_nonzero", n_nz, 2 * (H - 2));

    clear_stats();
    send_frame(2, 1'b0);
    idle(3);
    expect_count("ramp_fours", n_4, (H - 2) * (W - 2));
    expect_count("ramp_nonzero", n_nz, (H - 2) * (W - 2));

    clear_stats();
    send_frame(3, 1'b0);
    send_frame(3, 1'b1);
    idle(3);
    expect_count("random_outputs", n_out, 2 * N);

    for (int i = 0; i < 50; i++) send(int'($urandom_range(255)), 1'b0);
    idle(1);
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    mr = 0;
    mc = 0;
    clear_stats();
    send_frame(3, 1'b0);
    send_frame(2, 1'b0);
    idle(3);
    expect_count("post_reset_outputs", n_out, 2 * N);
    expect_count("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_sobels.md
Name: top_sobels

Overview:
Streaming Sobel edge-detection filter for 8-bit greyscale images sent in raster order, one pixel per valid cycle. It holds two line buffers and a 3x3 window, computes |Gx|+|Gy| saturated to the pixel width, and emits one output pixel per accepted input pixel. It sits between the pixel source (camera/DMA/file reader) and the pixel sink in the video datapath.

Parameters:
PX_SIZE, 8, pixel width in bits (input and output)
IMAGE_WIDTH, 400, pixels per line
IMAGE_HEIGHT, 400, lines per frame

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous, active-high reset (despite the name); 1 = reset
input_data  in  PX_SIZE  input pixel, unsigned, raster order
input_data_valid  in  1  input_data is valid this cycle; no backpressure
output_data  out  PX_SIZE  filtered pixel, unsigned
output_data_valid  out  1  output_data is valid this cycle

Behaviour:
- Reset (resetn=1 at a rising edge): output_data=0, output_data_valid=0, column/row counters=0, window registers=0. Line-buffer RAM contents are not cleared; border masking makes them irrelevant. Reset mid-frame: the next valid pixel is treated as (row 0, col 0).
- Accept: a pixel is consumed on each rising edge with input_data_valid=1 and reset=0. Cycles without valid change no state. On those cycles output_data_valid=0 and output_data holds its last value.
- Position: col counter 0..IMAGE_WIDTH-1 wraps to 0 and increments row. Row counter 0..IMAGE_HEIGHT-1 wraps to 0 (next frame). Counters advance only on accepted pixels.
- Window: 2 line buffers, each IMAGE_WIDTH x PX_SIZE, hold the previous two lines. On accept, shift in the column {line-2[c], line-1[c], input_data} (top to bottom) and update the line buffers at col c. The window p[i][j] (i=row 0..2 top to bottom, j=col 0..2 left to right) covers rows r-2..r and cols c-2..c, where (r,c) is the current pixel.
- Arithmetic, on the window that includes the current pixel:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Gx and Gy are signed, PX_SIZE+3 bits wide (range +/-1020 at 8 bits).
  - mag = |Gx|+|Gy| in PX_SIZE+4 bits, saturated to 2^PX_SIZE-1.
- Alignment: the output for input position (r,c) is the Sobel magnitude centred at (r-1,c-1). It is forced to 0 when r<2 or c<2, so the first two rows and the first two columns of every frame are 0. There is exactly one output per accepted input; a full frame yields IMAGE_WIDTH*IMAGE_HEIGHT outputs.
- Latency: 1 cycle. If a pixel is accepted at edge k, output_data/output_data_valid update at edge k, are visible in the following cycle, and output_data_valid is a registered copy of the accept.
- Continuous valid across frames is supported with no bubble. Window columns from the previous line never leak, because of the c<2 masking.

Decomposition:
- Shared package: PX_SIZE-derived constants GRAD_W=PX_SIZE+3 and MAG_W=PX_SIZE+4, PX_MAX=2^PX_SIZE-1, and the counter width function (clog2 of IMAGE_WIDTH/IMAGE_HEIGHT).
- One sub-module, sobel_window: counters, two line buffers, 3x3 window registers, and border flag out.
- top_sobels holds the gradient/saturation arithmetic and the output register.

Test Plan:
- Flat frame, all pixels 100 -> all 160000 outputs = 0; exactly 160000 outputs with output_data_valid=1.
- Vertical step, pixel = 0 for c<200 and 255 for c>=200 -> output 255 at r>=2, c in {200,201}; 0 elsewhere.
- Horizontal ramp, pixel = c/2 (integer division) -> output 4 for r>=2, c>=2 (Gx=4, Gy=0); 0 in the first two rows and columns.
- Border masking, random frame -> every output with r<2 or c<2 is 0; the rest match a golden model (|Gx|+|Gy| saturated to 255) centred at (r-1,c-1).
- Valid gaps, same random frame with input_data_valid dropped on a random 30% of cycles -> identical output sequence; output_data_valid=0 on every gap cycle; output_data held during gaps.
- Reset mid-frame: send 1000 pixels, assert resetn for one cycle, then send a full frame -> output_data=0 and output_data_valid=0 right after reset; the frame output equals that of a clean run; first output valid the cycle after the first accepted pixel.
